// File: rtl/lut_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lut_pkg
// Description : Shared types and constants for the LUT sweep evaluator:
//               FSM state encoding, operation mode codes and the helper
//               that derives the truth-table width from the input count.
// Revision    : 1.0 - initial release
// ============================================================================
package lut_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_SWEEP  = 1'b1;

    // One truth-table bit per input combination.
    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lut_sweep_eval_if.sv
`default_nettype none
// ============================================================================
// Module      : lut_sweep_eval_if
// Description : Host-side bundle of the LUT sweep evaluator.
//               master : host driving cfg_we/cfg_tt/start/mode/in_vec/abort
//                        and observing the report outputs.
//               slave  : the evaluator itself.
//               Outputs: busy, out_valid, out_vec, out_bit, done, result,
//                        ones_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
interface lut_sweep_eval_if
    import lut_pkg::*;
#(
    parameter  int N_IN = 4,
    localparam int TT_W = tt_width(N_IN)
) ();

    logic              cfg_we;
    logic [TT_W-1:0]   cfg_tt;
    logic              start;
    logic              mode;
    logic [N_IN-1:0]   in_vec;
    logic              abort;
    logic              busy;
    logic              out_valid;
    logic [N_IN-1:0]   out_vec;
    logic              out_bit;
    logic              done;
    logic [TT_W-1:0]   result;
    logic [N_IN:0]     ones_cnt;

    modport master (
        output cfg_we, cfg_tt, start, mode, in_vec, abort,
        input  busy, out_valid, out_vec, out_bit, done, result, ones_cnt
    );

    modport slave (
        input  cfg_we, cfg_tt, start, mode, in_vec, abort,
        output busy, out_valid, out_vec, out_bit, done, result, ones_cnt
    );

endinterface
`default_nettype wire

// File: rtl/lut_cell.sv
`default_nettype none
// ============================================================================
// Module      : lut_cell
// Description : Combinational N-input boolean function. Builds true and
//               complement rails from the index and forms the sum of the
//               minterms enabled by the truth table.
//   tt_i  [TT_W] : truth table, bit k = value for index k
//   idx_i [N_IN] : input vector (true rails), MSB = first variable
//   bit_o        : selected function value
// Revision    : 1.0 - initial release
// ============================================================================
module lut_cell
    import lut_pkg::*;
#(
    parameter  int N_IN = 4,
    localparam int TT_W = tt_width(N_IN)
) (
    input  wire  [TT_W-1:0] tt_i,
    input  wire  [N_IN-1:0] idx_i,
    output logic            bit_o
);

    logic [N_IN-1:0] w_rail_t;
    logic [N_IN-1:0] w_rail_c;
    logic [TT_W-1:0] w_term;

    assign w_rail_t = idx_i;
    assign w_rail_c = ~idx_i;

    // Minterm k: each variable taken from the true rail where bit j of k is
    // set, from the complement rail otherwise.
    for (genvar k = 0; k < TT_W; k++) begin : g_term
        logic [N_IN-1:0] w_lit;
        for (genvar j = 0; j < N_IN; j++) begin : g_lit
            if (((k >> j) & 1) != 0) begin : g_true
                assign w_lit[j] = w_rail_t[j];
            end else begin : g_comp
                assign w_lit[j] = w_rail_c[j];
            end
        end
        assign w_term[k] = tt_i[k] & (&w_lit);
    end

    assign bit_o = |w_term;

endmodule
`default_nettype wire

// File: rtl/lut_sweep_eval.sv
`default_nettype none
// ============================================================================
// Module      : lut_sweep_eval
// Description : Run-time programmable N-input truth table with single-vector
//               evaluation and exhaustive sweep of all input combinations.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lut_sweep_eval_if.slave (cfg_we/cfg_tt/start/mode/in_vec/
//                abort in; busy/out_valid/out_vec/out_bit/done/result/
//                ones_cnt out, all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module lut_sweep_eval
    import lut_pkg::*;
#(
    parameter  int N_IN = 4,
    localparam int TT_W = tt_width(N_IN)
) (
    input  wire            clk,
    input  wire            rst_n,
    lut_sweep_eval_if.slave bus
);

    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TT_W - 1);
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);

    state_t            state_q,     state_d;
    logic [TT_W-1:0]   tt_q,        tt_d;
    logic [N_IN-1:0]   idx_q,       idx_d;
    logic [TT_W-1:0]   result_q,    result_d;
    logic [N_IN:0]     ones_q,      ones_d;
    logic              busy_q,      busy_d;
    logic              out_valid_q, out_valid_d;
    logic [N_IN-1:0]   out_vec_q,   out_vec_d;
    logic              out_bit_q,   out_bit_d;
    logic              done_q,      done_d;
    logic              w_bit;

    // Looks up the index that will be reported next cycle, so the report
    // registers load in step with the state register.
    lut_cell #(.N_IN(N_IN)) u_cell (
        .tt_i  (tt_q),
        .idx_i (idx_d),
        .bit_o (w_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tt_q        <= '0;
            idx_q       <= '0;
            result_q    <= '0;
            ones_q      <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            out_bit_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tt_q        <= tt_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            ones_q      <= ones_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_vec_q   <= out_vec_d;
            out_bit_q   <= out_bit_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tt_d     = tt_q;
        idx_d    = idx_q;
        result_d = result_q;
        ones_d   = ones_q;

        case (state_q)
            IDLE: begin
                // A table write takes the cycle; a coincident start is dropped.
                if (bus.cfg_we) begin
                    tt_d = bus.cfg_tt;
                end else if (bus.start) begin
                    if (bus.mode == MODE_SWEEP) begin
                        state_d = SWEEP;
                        idx_d   = '0;
                        ones_d  = '0;
                    end else begin
                        state_d = EVAL;
                        idx_d   = bus.in_vec;
                    end
                end
            end
            EVAL: begin
                state_d = IDLE;
            end
            SWEEP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Capture happens on the same edge that loads the matching report,
        // so an abort leaves exactly the reported bits in result.
        if (state_d == SWEEP) begin
            result_d[idx_d] = w_bit;
            ones_d          = ones_d + (N_IN + 1)'(w_bit);
        end

        busy_d      = (state_d == EVAL) || (state_d == SWEEP);
        out_valid_d = busy_d;
        done_d      = (state_d == DONE);
        out_vec_d   = out_valid_d ? idx_d : out_vec_q;
        out_bit_d   = out_valid_d ? w_bit : out_bit_q;
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_vec   = out_vec_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.ones_cnt  = ones_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_sweep_eval.sv
`default_nettype none
// ============================================================================
// Module      : tb_lut_sweep_eval
// Description : Directed self-checking bench for lut_sweep_eval (N_IN = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_sweep_eval;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    lut_sweep_eval_if #(.N_IN(4)) bus ();

    lut_sweep_eval #(.N_IN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Optional table load, then a full sweep with every report checked.
    task automatic run_sweep(input logic do_load, input logic [15:0] tt,
                             input logic [15:0] exp_res, input logic [4:0] exp_ones);
        if (do_load) begin
            @(negedge clk);
            bus.cfg_we = 1'b1;
            bus.cfg_tt = tt;
            @(negedge clk);
            bus.cfg_we = 1'b0;
        end else begin
            @(negedge clk);
        end
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check("sweep_valid", bus.out_valid, 1);
            check("sweep_busy", bus.busy, 1);
            check("sweep_vec", bus.out_vec, i);
            check("sweep_bit", bus.out_bit, tt[i]);
            check("sweep_nodone", bus.done, 0);
        end
        @(negedge clk);
        check("done_pulse", bus.done, 1);
        check("done_busy", bus.busy, 0);
        check("done_valid", bus.out_valid, 0);
        check("done_result", bus.result, exp_res);
        check("done_ones", bus.ones_cnt, exp_ones);
        @(negedge clk);
        check("done_once", bus.done, 0);
        check("hold_result", bus.result, exp_res);
        check("hold_ones", bus.ones_cnt, exp_ones);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b1;
        bus.cfg_we = 1'b0;
        bus.cfg_tt = '0;
        bus.start  = 1'b0;
        bus.mode   = 1'b0;
        bus.in_vec = '0;
        bus.abort  = 1'b0;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_vec", bus.out_vec, 0);
        check("rst_bit", bus.out_bit, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_ones", bus.ones_cnt, 0);
        check("rst_table", dut.tt_q, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table load.
        @(negedge clk);
        bus.cfg_we = 1'b1;
        bus.cfg_tt = 16'hA5C3;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        check("load_table", dut.tt_q, 16'hA5C3);
        check("load_busy", bus.busy, 0);

        // Single evaluate, index 8 -> 1.
        bus.start  = 1'b1;
        bus.mode   = 1'b0;
        bus.in_vec = 4'b1000;
        @(negedge clk);
        bus.start = 1'b0;
        check("eval8_valid", bus.out_valid, 1);
        check("eval8_vec", bus.out_vec, 8);
        check("eval8_bit", bus.out_bit, 1);
        check("eval8_busy", bus.busy, 1);
        @(negedge clk);
        check("eval8_busy_end", bus.busy, 0);
        check("eval8_valid_end", bus.out_valid, 0);

        // Single evaluate, index 11 -> 0; abort has no effect here.
        bus.start  = 1'b1;
        bus.in_vec = 4'b1011;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        check("eval11_valid", bus.out_valid, 1);
        check("eval11_vec", bus.out_vec, 11);
        check("eval11_bit", bus.out_bit, 0);
        check("eval11_busy", bus.busy, 1);
        @(negedge clk);
        bus.abort = 1'b0;
        check("eval11_busy_end", bus.busy, 0);
        check("eval_result", bus.result, 0);
        check("eval_ones", bus.ones_cnt, 0);

        // Sweeps: existing table, all ones, all zeros.
        run_sweep(1'b0, 16'hA5C3, 16'hA5C3, 5'd8);
        run_sweep(1'b1, 16'hFFFF, 16'hFFFF, 5'b10000);
        run_sweep(1'b1, 16'h0000, 16'h0000, 5'd0);

        // Abort on the index-4 report of an all-ones sweep.
        @(negedge clk);
        bus.cfg_we = 1'b1;
        bus.cfg_tt = 16'hFFFF;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        bus.start  = 1'b1;
        bus.mode   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("abort_at_vec", bus.out_vec, 4);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_valid", bus.out_valid, 0);
        check("abort_nodone", bus.done, 0);
        check("abort_result", bus.result, 16'h001F);
        check("abort_ones", bus.ones_cnt, 5);
        @(negedge clk);
        check("abort_nodone2", bus.done, 0);
        check("abort_idle", bus.busy, 0);

        // cfg_we beats start in IDLE.
        bus.cfg_we = 1'b1;
        bus.cfg_tt = 16'h1234;
        bus.start  = 1'b1;
        bus.mode   = 1'b1;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        bus.start  = 1'b0;
        check("prio_table", dut.tt_q, 16'h1234);
        check("prio_busy", bus.busy, 0);
        check("prio_valid", bus.out_valid, 0);
        @(negedge clk);
        check("prio_busy2", bus.busy, 0);

        // cfg_we while sweeping is ignored.
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cfg_we = 1'b1;
        bus.cfg_tt = 16'hBEEF;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        check("frozen_table", dut.tt_q, 16'h1234);
        for (int i = 2; i < 8; i++) @(negedge clk);
        check("mid_vec", bus.out_vec, 7);

        // Reset in the middle of that sweep.
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_valid", bus.out_valid, 0);
        check("midrst_result", bus.result, 0);
        check("midrst_ones", bus.ones_cnt, 0);
        check("midrst_table", dut.tt_q, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep of the cleared table.
        run_sweep(1'b0, 16'h0000, 16'h0000, 5'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
